// File: rtl/common_pkg.sv
// Shared machine-wide types: memory address and data word.
package common;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef logic [ADDR_W-1:0] memaddr_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage : common

// File: rtl/cpu_common_pkg.sv
// CPU-side types shared by the cache front ends and the memory arbiter.
package cpu_common;

    import common::*;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_id_t;

    // One registered memory request as it sits in the arbiter output stage.
    typedef struct packed {
        memaddr_t addr;
        word_t    wdata;
        logic     we;
    } mem_req_t;

    function automatic requester_id_t other_requester(input requester_id_t id);
        return (id == ICACHE) ? DCACHE : ICACHE;
    endfunction

endpackage : cpu_common

// File: rtl/mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for issued, unanswered memory requests.
// Head entry names the owner of the next memory response.
module id_fifo
    import cpu_common::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  requester_id_t push_id_i,
    input  logic          pop_i,
    output requester_id_t head_id_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    requester_id_t mem_q [DEPTH];
    requester_id_t mem_d [DEPTH];
    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    cnt_t          count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == cnt_t'(DEPTH));
    assign head_id_o = mem_q[rd_ptr_q];

    // A push while full is legal only alongside a pop: the slot being
    // written is the head slot that is leaving in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read once the count says it was written, so reset logic buys nothing.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule : id_fifo

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the icache
// and dcache: registered request stage, combinational response routing.
module mem_arbiter
    import common::*;
    import cpu_common::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,

    input  memaddr_t icache_req_addr_i,
    input  logic     icache_req_valid_i,
    output logic     icache_req_ready_o,
    output word_t    icache_resp_data_o,
    output logic     icache_resp_valid_o,
    input  logic     icache_resp_ready_i,

    input  memaddr_t dcache_req_addr_i,
    input  word_t    dcache_req_wdata_i,
    input  logic     dcache_req_we_i,
    input  logic     dcache_req_valid_i,
    output logic     dcache_req_ready_o,
    output word_t    dcache_resp_data_o,
    output logic     dcache_resp_valid_o,
    input  logic     dcache_resp_ready_i,

    output memaddr_t mem_req_addr_o,
    output word_t    mem_req_wdata_o,
    output logic     mem_req_we_o,
    output logic     mem_req_valid_o,
    input  logic     mem_req_ready_i,
    input  word_t    mem_resp_data_i,
    input  logic     mem_resp_valid_i,
    output logic     mem_resp_ready_o,

    output logic     spurious_o
);

    mem_req_t      out_q, out_d;
    logic          out_valid_q, out_valid_d;
    requester_id_t last_grant_q, last_grant_d;
    logic          spurious_q, spurious_d;

    requester_id_t grant_id;
    logic          grant_valid;
    logic          stage_free;
    logic          accept;
    logic          resp_hs;

    requester_id_t head_id;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ICACHE;
        case ({icache_req_valid_i, dcache_req_valid_i})
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = ICACHE;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = DCACHE;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = other_requester(last_grant_q);
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = ICACHE;
            end
        endcase
    end

    // Readies are gated by rst_ni so they drop the instant reset asserts.
    assign stage_free = !out_valid_q || mem_req_ready_i;
    assign accept     = rst_ni && stage_free && !fifo_full && grant_valid;

    assign icache_req_ready_o = accept && (grant_id == ICACHE);
    assign dcache_req_ready_o = accept && (grant_id == DCACHE);

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            last_grant_d = grant_id;
            if (grant_id == ICACHE) begin
                out_d = '{addr: icache_req_addr_i, wdata: '0, we: 1'b0};
            end else begin
                out_d = '{addr: dcache_req_addr_i, wdata: dcache_req_wdata_i,
                          we: dcache_req_we_i};
            end
        end else if (mem_req_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    assign mem_req_valid_o = out_valid_q;
    assign mem_req_addr_o  = out_q.addr;
    assign mem_req_wdata_o = out_q.wdata;
    assign mem_req_we_o    = out_q.we;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign icache_resp_data_o = mem_resp_data_i;
    assign dcache_resp_data_o = mem_resp_data_i;

    always_comb begin
        icache_resp_valid_o = 1'b0;
        dcache_resp_valid_o = 1'b0;
        mem_resp_ready_o    = 1'b0;

        if (fifo_empty) begin
            // Nobody is waiting: swallow the response so memory never hangs.
            mem_resp_ready_o = rst_ni;
        end else if (head_id == ICACHE) begin
            icache_resp_valid_o = mem_resp_valid_i;
            mem_resp_ready_o    = icache_resp_ready_i;
        end else begin
            dcache_resp_valid_o = mem_resp_valid_i;
            mem_resp_ready_o    = dcache_resp_ready_i;
        end
    end

    assign resp_hs    = mem_resp_valid_i && mem_resp_ready_o;
    assign fifo_pop   = resp_hs && !fifo_empty;
    assign spurious_d = spurious_q || (resp_hs && fifo_empty);
    assign spurious_o = spurious_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= ICACHE;
            spurious_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            spurious_q   <= spurious_d;
        end
    end

    id_fifo #(
        .DEPTH(DEPTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (accept),
        .push_id_i (grant_id),
        .pop_i     (fifo_pop),
        .head_id_o (head_id),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for arbitration
// and routing, plus hand sequences for stall, full FIFO, writes and reset.
module tb_mem_arbiter;

    import common::*;

    localparam memaddr_t IA = 32'h0000_0100;
    localparam memaddr_t DA = 32'h0000_0200;

    logic     clk_i = 1'b0;
    logic     rst_ni;
    memaddr_t icache_req_addr_i;
    logic     icache_req_valid_i;
    logic     icache_req_ready_o;
    word_t    icache_resp_data_o;
    logic     icache_resp_valid_o;
    logic     icache_resp_ready_i;
    memaddr_t dcache_req_addr_i;
    word_t    dcache_req_wdata_i;
    logic     dcache_req_we_i;
    logic     dcache_req_valid_i;
    logic     dcache_req_ready_o;
    word_t    dcache_resp_data_o;
    logic     dcache_resp_valid_o;
    logic     dcache_resp_ready_i;
    memaddr_t mem_req_addr_o;
    word_t    mem_req_wdata_o;
    logic     mem_req_we_o;
    logic     mem_req_valid_o;
    logic     mem_req_ready_i;
    word_t    mem_resp_data_i;
    logic     mem_resp_valid_i;
    logic     mem_resp_ready_o;
    logic     spurious_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.DEPTH(4)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .icache_req_addr_i   (icache_req_addr_i),
        .icache_req_valid_i  (icache_req_valid_i),
        .icache_req_ready_o  (icache_req_ready_o),
        .icache_resp_data_o  (icache_resp_data_o),
        .icache_resp_valid_o (icache_resp_valid_o),
        .icache_resp_ready_i (icache_resp_ready_i),
        .dcache_req_addr_i   (dcache_req_addr_i),
        .dcache_req_wdata_i  (dcache_req_wdata_i),
        .dcache_req_we_i     (dcache_req_we_i),
        .dcache_req_valid_i  (dcache_req_valid_i),
        .dcache_req_ready_o  (dcache_req_ready_o),
        .dcache_resp_data_o  (dcache_resp_data_o),
        .dcache_resp_valid_o (dcache_resp_valid_o),
        .dcache_resp_ready_i (dcache_resp_ready_i),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_req_wdata_o     (mem_req_wdata_o),
        .mem_req_we_o        (mem_req_we_o),
        .mem_req_valid_o     (mem_req_valid_o),
        .mem_req_ready_i     (mem_req_ready_i),
        .mem_resp_data_i     (mem_resp_data_i),
        .mem_resp_valid_i    (mem_resp_valid_i),
        .mem_resp_ready_o    (mem_resp_ready_o),
        .spurious_o          (spurious_o)
    );

    // stim = {icache_valid, dcache_valid, mem_req_ready, mem_resp_valid}
    // exp  = {icache_ready, dcache_ready, mem_req_valid, icache_rv, dcache_rv}
    typedef struct {
        logic [3:0] stim;
        word_t      rdata;
        logic [4:0] exp;
        memaddr_t   e_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        icache_req_addr_i   = IA;
        icache_req_valid_i  = 1'b0;
        icache_resp_ready_i = 1'b1;
        dcache_req_addr_i   = DA;
        dcache_req_wdata_i  = '0;
        dcache_req_we_i     = 1'b0;
        dcache_req_valid_i  = 1'b0;
        dcache_resp_ready_i = 1'b1;
        mem_req_ready_i     = 1'b1;
        mem_resp_data_i     = '0;
        mem_resp_valid_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Advance to the next falling edge, where inputs are changed.
    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;

        vecs[0]  = '{4'b1110, 32'h0,  5'b01000, 32'h0};
        vecs[1]  = '{4'b1110, 32'h0,  5'b10100, DA};
        vecs[2]  = '{4'b1111, 32'h11, 5'b01101, IA};
        vecs[3]  = '{4'b1111, 32'h22, 5'b10110, DA};
        vecs[4]  = '{4'b0011, 32'h33, 5'b00101, IA};
        vecs[5]  = '{4'b0011, 32'h44, 5'b00010, IA};
        vecs[6]  = '{4'b1000, 32'h0,  5'b10000, IA};
        vecs[7]  = '{4'b0100, 32'h0,  5'b00100, IA};
        vecs[8]  = '{4'b0110, 32'h0,  5'b01100, IA};
        vecs[9]  = '{4'b0010, 32'h0,  5'b00100, DA};
        vecs[10] = '{4'b0011, 32'h55, 5'b00010, DA};
        vecs[11] = '{4'b0011, 32'h66, 5'b00001, DA};
        vecs[12] = '{4'b0010, 32'h0,  5'b00000, DA};

        idle_inputs();
        rst_ni = 1'b0;
        #2;
        check("reset mem_req_valid", mem_req_valid_o, 0);
        check("reset spurious", spurious_o, 0);
        check("reset icache_resp_valid", icache_resp_valid_o, 0);
        do_reset();

        // Table: alternating grants, in-order routing, stall and single requesters.
        for (int i = 0; i < 13; i++) begin
            cyc();
            icache_req_valid_i = vecs[i].stim[3];
            dcache_req_valid_i = vecs[i].stim[2];
            mem_req_ready_i    = vecs[i].stim[1];
            mem_resp_valid_i   = vecs[i].stim[0];
            mem_resp_data_i    = vecs[i].rdata;
            #1;
            check($sformatf("v%0d icache_ready", i), icache_req_ready_o, vecs[i].exp[4]);
            check($sformatf("v%0d dcache_ready", i), dcache_req_ready_o, vecs[i].exp[3]);
            check($sformatf("v%0d mem_req_valid", i), mem_req_valid_o, vecs[i].exp[2]);
            check($sformatf("v%0d mem_req_addr", i), mem_req_addr_o, vecs[i].e_addr);
            check($sformatf("v%0d icache_resp_valid", i), icache_resp_valid_o, vecs[i].exp[1]);
            check($sformatf("v%0d dcache_resp_valid", i), dcache_resp_valid_o, vecs[i].exp[0]);
            if (vecs[i].stim[0]) begin
                check($sformatf("v%0d mem_resp_ready", i), mem_resp_ready_o, 1);
                if (vecs[i].exp[1])
                    check($sformatf("v%0d icache_data", i), icache_resp_data_o, vecs[i].rdata);
                if (vecs[i].exp[0])
                    check($sformatf("v%0d dcache_data", i), dcache_resp_data_o, vecs[i].rdata);
            end
        end
        check("table spurious", spurious_o, 0);

        // Stalled icache read at 0x10 holds the port; waiting dcache is not granted.
        do_reset();
        cyc();
        icache_req_addr_i  = 32'h10;
        icache_req_valid_i = 1'b1;
        mem_req_ready_i    = 1'b0;
        #1;
        check("stall icache_ready", icache_req_ready_o, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            icache_req_valid_i = 1'b0;
            dcache_req_valid_i = 1'b1;
            mem_req_ready_i    = (k == 3);
            #1;
            check($sformatf("stall%0d mem_req_valid", k), mem_req_valid_o, 1);
            check($sformatf("stall%0d mem_req_addr", k), mem_req_addr_o, 32'h10);
            check($sformatf("stall%0d dcache_ready", k), dcache_req_ready_o, (k == 3));
        end
        cyc();
        dcache_req_valid_i = 1'b0;
        #1;
        check("stall next addr", mem_req_addr_o, DA);

        // Full ID FIFO: five offered, four accepted, one response frees a slot.
        do_reset();
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            icache_req_valid_i = 1'b1;
            dcache_req_valid_i = 1'b1;
            #1;
            if (icache_req_ready_o || dcache_req_ready_o) accepted++;
        end
        check("full accepted", accepted, 4);
        check("full icache_ready", icache_req_ready_o, 0);
        check("full dcache_ready", dcache_req_ready_o, 0);
        cyc();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h77;
        #1;
        check("full resp icache_ready", icache_req_ready_o, 0);
        check("full resp dcache_ready", dcache_req_ready_o, 0);
        check("full resp mem_resp_ready", mem_resp_ready_o, 1);
        check("full resp dcache_rv", dcache_resp_valid_o, 1);
        cyc();
        mem_resp_valid_i = 1'b0;
        #1;
        check("after pop dcache_ready", dcache_req_ready_o, 1);
        check("after pop icache_ready", icache_req_ready_o, 0);

        // Mixed I, D write, I; then routing with a dcache response stall.
        do_reset();
        dcache_req_addr_i  = 32'h40;
        dcache_req_wdata_i = 32'hDEADBEEF;
        dcache_req_we_i    = 1'b1;
        cyc();
        icache_req_addr_i  = 32'h30;
        icache_req_valid_i = 1'b1;
        #1;
        check("mix i0 ready", icache_req_ready_o, 1);
        cyc();
        icache_req_valid_i = 1'b0;
        dcache_req_valid_i = 1'b1;
        #1;
        check("mix d ready", dcache_req_ready_o, 1);
        check("mix i0 addr", mem_req_addr_o, 32'h30);
        check("mix i0 we", mem_req_we_o, 0);
        check("mix i0 wdata", mem_req_wdata_o, 0);
        cyc();
        dcache_req_valid_i = 1'b0;
        icache_req_addr_i  = 32'h50;
        icache_req_valid_i = 1'b1;
        #1;
        check("mix i1 ready", icache_req_ready_o, 1);
        check("mix d addr", mem_req_addr_o, 32'h40);
        check("mix d we", mem_req_we_o, 1);
        check("mix d wdata", mem_req_wdata_o, 32'hDEADBEEF);
        cyc();
        icache_req_valid_i = 1'b0;
        #1;
        check("mix i1 addr", mem_req_addr_o, 32'h50);
        check("mix i1 we", mem_req_we_o, 0);
        check("mix i1 wdata", mem_req_wdata_o, 0);
        cyc();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hAAAA0001;
        #1;
        check("rsp1 icache_rv", icache_resp_valid_o, 1);
        check("rsp1 dcache_rv", dcache_resp_valid_o, 0);
        check("rsp1 data", icache_resp_data_o, 32'hAAAA0001);
        cyc();
        mem_resp_data_i     = 32'hBBBB0002;
        dcache_resp_ready_i = 1'b0;
        #1;
        check("rsp2 stall dcache_rv", dcache_resp_valid_o, 1);
        check("rsp2 stall icache_rv", icache_resp_valid_o, 0);
        check("rsp2 stall mem_resp_ready", mem_resp_ready_o, 0);
        cyc();
        dcache_resp_ready_i = 1'b1;
        #1;
        check("rsp2 dcache_rv", dcache_resp_valid_o, 1);
        check("rsp2 mem_resp_ready", mem_resp_ready_o, 1);
        check("rsp2 data", dcache_resp_data_o, 32'hBBBB0002);
        cyc();
        mem_resp_data_i = 32'hCCCC0003;
        #1;
        check("rsp3 icache_rv", icache_resp_valid_o, 1);
        check("rsp3 dcache_rv", dcache_resp_valid_o, 0);
        check("rsp3 data", icache_resp_data_o, 32'hCCCC0003);

        // Response with nothing outstanding: swallowed, flag sticks.
        cyc();
        mem_resp_data_i = 32'hEEEE0004;
        #1;
        check("spur mem_resp_ready", mem_resp_ready_o, 1);
        check("spur icache_rv", icache_resp_valid_o, 0);
        check("spur dcache_rv", dcache_resp_valid_o, 0);
        check("spur before edge", spurious_o, 0);
        cyc();
        mem_resp_valid_i = 1'b0;
        #1;
        check("spur set", spurious_o, 1);
        for (int k = 0; k < 3; k++) cyc();
        check("spur sticky", spurious_o, 1);

        // Reset pulse with two requests outstanding.
        do_reset();
        check("rst2 spurious cleared", spurious_o, 0);
        cyc();
        icache_req_valid_i = 1'b1;
        dcache_req_valid_i = 1'b1;
        cyc();
        cyc();
        rst_ni           = 1'b0;
        mem_resp_valid_i = 1'b1;
        #1;
        check("rst2 mem_req_valid", mem_req_valid_o, 0);
        check("rst2 icache_ready", icache_req_ready_o, 0);
        check("rst2 dcache_ready", dcache_req_ready_o, 0);
        check("rst2 mem_resp_ready", mem_resp_ready_o, 0);
        check("rst2 icache_rv", icache_resp_valid_o, 0);
        check("rst2 dcache_rv", dcache_resp_valid_o, 0);
        cyc();
        rst_ni             = 1'b1;
        icache_req_valid_i = 1'b0;
        dcache_req_valid_i = 1'b0;
        #1;
        check("post rst icache_rv", icache_resp_valid_o, 0);
        check("post rst dcache_rv", dcache_resp_valid_o, 0);
        check("post rst mem_resp_ready", mem_resp_ready_o, 1);
        cyc();
        mem_resp_valid_i = 1'b0;
        #1;
        check("post rst spurious", spurious_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
